// File: rtl/adc_seq_pkg.sv
// ---------------------------------------------------------------------------
// adc_seq_pkg
//   Shared definitions for the ADC burst sequencer: ADC code width, the
//   sequencer state encoding and the accumulator sizing helper.
// ---------------------------------------------------------------------------
package adc_seq_pkg;

    localparam int ADC_BITS = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAKE = 2'd1,
        ACQ  = 2'd2
    } adc_seq_state_t;

    // Summing 2^avg_log2 codes of ADC_BITS each needs avg_log2 extra bits.
    function automatic int acc_width(input int avg_log2);
        return ADC_BITS + avg_log2;
    endfunction

endpackage

// File: rtl/adc_seq_fifo.sv
// ---------------------------------------------------------------------------
// adc_seq_fifo
//   Synchronous FIFO holding averaged ADC words until the consumer takes them.
//   Ports:
//     clk, rst      clock, asynchronous active-high reset (empties the FIFO)
//     push, din     write request and data; ignored when full unless a pop
//                   happens in the same cycle
//     pop           read request; ignored when empty
//     full, empty   occupancy flags derived from the pointers
//     head          word at the read pointer
// ---------------------------------------------------------------------------
module adc_seq_fifo #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    // Pointers carry one extra bit so full and empty can be told apart.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot the push is about to use.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            // NOTE: the storage is reset so head reads 0 out of reset; it is
            // only DEPTH small words, so a reset on each entry is affordable.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // pre-edge values regardless of statement order.
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= din;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/adc_seq_ctrl.sv
// ---------------------------------------------------------------------------
// adc_seq_ctrl
//   Burst sequencer for the 6-bit flash ADC: wakes the ADC, waits for it to
//   settle, block-averages 2^AVG_LOG2 codes per output word, queues words in
//   a FIFO and powers the ADC back down at the end of the burst.
//   Ports:
//     clk, rst        clock shared with the ADC, async active-high reset
//     start, stop     one-cycle burst request / abort (stop wins over start)
//     burst_len       words per burst, 0 = run until stop
//     adc_pd          ADC power-down (1 = powered down)
//     adc_code        ADC output code, sampled every cycle in ACQ
//     out_data/out_valid/out_ready   result stream from the FIFO head
//     busy, done      sequencer active / one-cycle end-of-burst pulse
//     overflow        sticky: a word was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module adc_seq_ctrl
    import adc_seq_pkg::*;
#(
    parameter int WAKE_CYC   = 8,
    parameter int AVG_LOG2   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic [7:0]          burst_len,
    output logic                adc_pd,
    input  logic [ADC_BITS-1:0] adc_code,
    output logic [ADC_BITS-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done,
    output logic                overflow
);

    localparam int ACC_W = acc_width(AVG_LOG2);
    localparam int SC_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [SC_W-1:0] SAMP_LAST = SC_W'((1 << AVG_LOG2) - 1);
    localparam logic [SC_W-1:0] SC_ONE    = 1;
    localparam logic [7:0]      WAKE_LAST = 8'(WAKE_CYC - 1);

    adc_seq_state_t state;
    adc_seq_state_t next_state;

    logic [7:0]          wake_cnt;
    logic [7:0]          word_cnt;
    logic [7:0]          len_q;
    logic [SC_W-1:0]     samp_cnt;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    sum;
    logic                push_q;
    logic [ADC_BITS-1:0] push_data_q;

    logic start_acc;
    logic sample_last;
    logic last_word;
    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic pd_d;
    logic busy_d;
    logic done_d;

    assign start_acc   = (state == IDLE) && start && !stop;
    assign sample_last = (samp_cnt == SAMP_LAST);
    assign sum         = acc + ACC_W'(adc_code);
    assign last_word   = sample_last && (len_q != 8'd0) &&
                         (word_cnt == len_q - 8'd1);
    assign out_valid   = !fifo_empty;
    assign pop         = out_valid && out_ready;

    // State register plus registered outputs, which trail the state by one
    // cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            adc_pd <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= next_state;
            adc_pd <= pd_d;
            busy   <= busy_d;
            done   <= done_d;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch
        // is inferred.
        next_state = state;
        case (state)
            IDLE: if (start_acc) next_state = WAKE;
            WAKE: begin
                if (stop) begin
                    next_state = IDLE;
                end else if (!adc_pd && wake_cnt == WAKE_LAST) begin
                    next_state = ACQ;
                end
            end
            ACQ:  if (stop || last_word) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // busy still reflects the previous state, so IDLE with busy high is the
    // first cycle after a burst ended: that is exactly where done pulses.
    always_comb begin
        pd_d   = (state == IDLE);
        busy_d = (state != IDLE);
        done_d = (state == IDLE) && busy;
    end

    // Wake timing, averaging, word counting and overflow tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wake_cnt    <= '0;
            word_cnt    <= '0;
            len_q       <= '0;
            samp_cnt    <= '0;
            acc         <= '0;
            push_q      <= 1'b0;
            push_data_q <= '0;
            overflow    <= 1'b0;
        end else begin
            push_q <= 1'b0;

            if (start_acc) begin
                len_q    <= burst_len;
                word_cnt <= '0;
            end

            // Settling time is counted only once adc_pd is actually low.
            if (state != WAKE) begin
                wake_cnt <= '0;
            end else if (!adc_pd) begin
                wake_cnt <= wake_cnt + 8'd1;
            end

            if (state == ACQ) begin
                if (sample_last) begin
                    // A push due on the stop cycle is still taken.
                    push_q      <= 1'b1;
                    push_data_q <= sum[ACC_W-1:AVG_LOG2];
                    acc         <= '0;
                    samp_cnt    <= '0;
                    word_cnt    <= word_cnt + 8'd1;
                end else if (stop) begin
                    acc      <= '0;
                    samp_cnt <= '0;
                end else begin
                    acc      <= sum;
                    samp_cnt <= samp_cnt + SC_ONE;
                end
            end else begin
                acc      <= '0;
                samp_cnt <= '0;
            end

            if (start_acc) begin
                overflow <= 1'b0;
            end
            if (push_q && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    adc_seq_fifo #(
        .WIDTH (ADC_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_q),
        .pop   (pop),
        .din   (push_data_q),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (out_data)
    );

endmodule

// File: doc/adc_seq_ctrl.md
Name: adc_seq_ctrl

Overview:
Sequencer for the 6-bit flash ADC model.
- Owns the ADC power-down line: wakes the ADC on command, waits a settling interval, captures a burst of conversions, then powers it back down.
- Decimates by block-averaging 2^AVG_LOG2 codes.
- Buffers results in a small FIFO and presents them on a valid/ready stream to downstream DSP or test logic.

Parameters:
WAKE_CYC, 8, cycles adc_pd is held low before the first code is accepted (covers ADC output register latency); range 2..255
AVG_LOG2, 2, log2 of codes averaged per output word; range 0..4
FIFO_DEPTH, 4, output FIFO entries; power of two, 2..16

Ports:
clk  in  1  system clock; ADC shares this clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle request to begin a burst
stop  in  1  one-cycle abort request
burst_len  in  8  output words per burst; 0 = continuous until stop
adc_pd  out  1  ADC power-down drive (1 = powered down)
adc_code  in  6  ADC output code
out_data  out  6  averaged code at FIFO head
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer accepts out_data when out_valid && out_ready
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when a burst completes or is aborted
overflow  out  1  sticky: a result was dropped because the FIFO was full

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: adc_pd=1, busy=0, done=0, overflow=0, out_valid=0, out_data=0. FIFO empty, all counters 0, state IDLE. Reset mid-burst behaves identically and discards all FIFO contents.
- All outputs are registered. adc_code is sampled on every posedge in ACQ.
- State IDLE: adc_pd=1.
  - start && !stop: latch burst_len, clear overflow, go to WAKE.
  - start && stop in the same cycle: stop wins, stay IDLE, no done.
- State WAKE: adc_pd=0. Wake counter runs 0..WAKE_CYC-1, then go to ACQ. stop: go to IDLE, pulse done.
- State ACQ: adc_pd=0.
  - Each cycle: acc += adc_code; sample count increments.
  - When sample count reaches 2^AVG_LOG2-1: push (acc + adc_code) >> AVG_LOG2 (truncating), clear acc, increment word count.
  - Accumulator width is 6+AVG_LOG2 bits; no saturation is needed.
  - When word count reaches burst_len (burst_len != 0): go to IDLE and pulse done in the cycle after the final push.
  - stop: discard the partial accumulation, go to IDLE, pulse done. A push scheduled in the same cycle as stop still occurs.
- start while busy is ignored. burst_len changes mid-burst have no effect.
- Push into a full FIFO: word is dropped, overflow set (sticky until the next accepted start), and the word still counts toward burst_len.
- A simultaneous pop and push when full: the pop frees the slot, the push succeeds, no overflow.
- FIFO contents persist across IDLE and drain normally after the burst ends.
- Latency with defaults: start accepted at edge 0 → adc_pd low after edge 1 → ACQ entered after edge 9 → first push at edge 13 → out_valid high after edge 14.
- out_data and out_valid are stable while out_valid && !out_ready.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are tracked with an extra pointer bit.

Decomposition:
- Package adc_seq_pkg:
  - ADC_BITS=6.
  - State enum {IDLE, WAKE, ACQ}.
  - Helper function for accumulator width.
- Sub-module adc_seq_fifo: synchronous FIFO with parameters WIDTH and DEPTH and ports push/pop/full/empty/head. It is instantiated once.
- Sequencing, averaging and counters stay in the top module.

Test Plan:
- Wake timing: start pulse at edge 0, ADC in=0.0 (code 32), burst_len=1, out_ready=1 → adc_pd low edges 1..13; out_valid at edge 14 with out_data=32; done pulse at edge 14; adc_pd=1 from then on.
- Averaging: driven codes 10,11,12,13 then 63,63,63,62, burst_len=2 → out_data 11 then 62; full-scale in=2.95 → 63; in=-3.1 → 0.
- Backpressure/overflow: FIFO_DEPTH=4, out_ready=0, burst_len=6 → 4 words held, overflow=1 after the 5th push, done after the 6th. Raising out_ready then yields exactly the first 4 words in order, and out_valid falls.
- Abort: burst_len=0, stop 2 cycles into ACQ → no word pushed, done pulse, adc_pd=1 next cycle. start+stop in the same cycle while IDLE → stays IDLE, no done.
- Reset mid-burst: assert rst asynchronously between edges during ACQ with 2 words queued → adc_pd=1, out_valid=0, busy=0 immediately, without waiting for a clock edge.
- Continuous with full-when-pop: burst_len=0, out_ready toggling 1/0, FIFO_DEPTH=2 → no overflow while each pop coincides with a push at full; overflow=1 once out_ready stays 0 for 3 outputs.
